// File: rtl/mul_seq_8b.sv
// rtl/mul_seq_8b.sv - shift-and-add unsigned multiplier sequencer driving an external ripple adder
module mul_seq_8b #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   adder_a,
  output logic [WIDTH-1:0]   adder_b,
  output logic               adder_cin,
  input  logic [WIDTH-1:0]   adder_sum,
  input  logic               adder_cout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_step;

  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      mcand_q  <= mcand_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    mcand_d  = mcand_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_CALC: begin
        // Carry lands in the top bit of acc_hi; the shifted-out LSB of acc_lo is consumed.
        {acc_hi_d, acc_lo_d} = {adder_cout, adder_sum, acc_lo_q[WIDTH-1:1]};
        if (last_step) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_CALC;
          mcand_d  = op_a;
          acc_lo_d = op_b;
          acc_hi_d = '0;
          cnt_d    = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q == S_CALC);
  assign done      = (state_q == S_DONE);
  assign product   = {acc_hi_q, acc_lo_q};
  assign adder_a   = acc_hi_q;
  assign adder_b   = (busy && acc_lo_q[0]) ? mcand_q : '0;
  assign adder_cin = 1'b0;

endmodule

// File: tb/tb_mul_seq_8b.sv
// tb/tb_mul_seq_8b.sv - self-checking bench for mul_seq_8b with a behavioural adder and product model
module tb_mul_seq_8b;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  op_a = 8'h00;
  logic [7:0]  op_b = 8'h00;
  logic        busy, done;
  logic [15:0] product;
  logic [7:0]  adder_a, adder_b, adder_sum;
  logic        adder_cin, adder_cout;

  int n_cmp = 0;
  int n_err = 0;
  int overlap = 0;

  mul_seq_8b #(.WIDTH(8), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .product(product),
    .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
    .adder_sum(adder_sum), .adder_cout(adder_cout)
  );

  // External ripple adder stand-in
  assign {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b} + {8'd0, adder_cin};

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0; op_a = 8'($urandom); op_b = 8'($urandom);
  endtask

  // Called on the negedge after the accept edge; returns on the negedge where done is high.
  task automatic wait_result(input logic [7:0] a, input logic [7:0] b, input bit poke,
                             input bit trail, input string tag);
    int busy_n = 0;
    bit seen = 1'b0;
    int unsigned ea = a;
    int unsigned eb = b;
    for (int i = 0; i < 20; i++) begin
      if (busy && done) overlap++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_n++;
      if (poke && i == 3) begin
        start = 1'b1; op_a = 8'h55; op_b = 8'h77;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
    check_eq({tag, "_busy_cycles"}, busy_n, 32'd8);
    check_eq({tag, "_product"}, 32'(product), ea * eb);
    if (trail) begin
      @(negedge clk);
      check_eq({tag, "_single_done"}, 32'(done), 32'd0);
      check_eq({tag, "_held"}, 32'(product), ea * eb);
    end
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit poke, input string tag);
    issue(a, b);
    wait_result(a, b, poke, 1'b1, tag);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_product", 32'(product), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("idle_busy", 32'(busy), 32'd0);

    run_op(8'h0F, 8'h0F, 1'b0, "t1");
    run_op(8'hFF, 8'hFF, 1'b0, "t2");
    run_op(8'h00, 8'hAB, 1'b0, "t3a");
    run_op(8'h80, 8'h02, 1'b0, "t3b");
    run_op(8'h0F, 8'h0F, 1'b1, "t4");

    issue(8'h0F, 8'h0F);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("t5_busy", 32'(busy), 32'd0);
    check_eq("t5_done", 32'(done), 32'd0);
    check_eq("t5_product", 32'(product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("t5_idle_busy", 32'(busy), 32'd0);
      check_eq("t5_idle_done", 32'(done), 32'd0);
    end

    issue(8'h0F, 8'h0F);
    wait_result(8'h0F, 8'h0F, 1'b0, 1'b0, "t6a");
    start = 1'b1; op_a = 8'h03; op_b = 8'h05;
    @(negedge clk);
    check_eq("t6_no_idle", 32'(busy), 32'd1);
    start = 1'b0; op_a = 8'($urandom); op_b = 8'($urandom);
    wait_result(8'h03, 8'h05, 1'b0, 1'b1, "t6b");

    for (int k = 0; k < 24; k++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_op(ra, rb, 1'($urandom_range(0, 1)), "rnd");
    end

    check_eq("busy_done_overlap", overlap, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
